// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 membrane keypad: key codes (same encoding
// as the scanner's DecodeOut), one-hot column/row constants, the emulator
// FSM state type, a debug struct and the key -> (column,row) map.
// Column/row one-hots use bit3 = C1/R1 ... bit0 = C4/R4, active-high here;
// the active-low pin polarity is applied where the pins are driven.
package keypad_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  localparam logic [3:0] COL_C1 = 4'b1000;
  localparam logic [3:0] COL_C2 = 4'b0100;
  localparam logic [3:0] COL_C3 = 4'b0010;
  localparam logic [3:0] COL_C4 = 4'b0001;
  localparam logic [3:0] ROW_R1 = 4'b1000;
  localparam logic [3:0] ROW_R2 = 4'b0100;
  localparam logic [3:0] ROW_R3 = 4'b0010;
  localparam logic [3:0] ROW_R4 = 4'b0001;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0] col;
    logic [3:0] row;
  } rc_t;

  // Observation bundle: FSM state, latched key and bounce LFSR.
  typedef struct packed {
    state_e      state;
    logic [3:0]  key;
    logic [15:0] lfsr;
  } dbg_t;

  function automatic rc_t key_to_rc(input logic [3:0] key);
    rc_t rc;
    rc = '{col: COL_C1, row: ROW_R1};
    case (key)
      KEY_1: rc = '{col: COL_C1, row: ROW_R1};
      KEY_4: rc = '{col: COL_C1, row: ROW_R2};
      KEY_7: rc = '{col: COL_C1, row: ROW_R3};
      KEY_0: rc = '{col: COL_C1, row: ROW_R4};
      KEY_2: rc = '{col: COL_C2, row: ROW_R1};
      KEY_5: rc = '{col: COL_C2, row: ROW_R2};
      KEY_8: rc = '{col: COL_C2, row: ROW_R3};
      KEY_F: rc = '{col: COL_C2, row: ROW_R4};
      KEY_3: rc = '{col: COL_C3, row: ROW_R1};
      KEY_6: rc = '{col: COL_C3, row: ROW_R2};
      KEY_9: rc = '{col: COL_C3, row: ROW_R3};
      KEY_E: rc = '{col: COL_C3, row: ROW_R4};
      KEY_A: rc = '{col: COL_C4, row: ROW_R1};
      KEY_B: rc = '{col: COL_C4, row: ROW_R2};
      KEY_C: rc = '{col: COL_C4, row: ROW_R3};
      KEY_D: rc = '{col: COL_C4, row: ROW_R4};
      default: rc = '{col: COL_C1, row: ROW_R1};
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if
// Key-press command channel into the keypad emulator.
//   cmd_valid : producer has a command on cmd_key/cmd_hold
//   cmd_ready : emulator can take a command (idle)
//   cmd_key   : key code to press
//   cmd_hold  : stable-closed duration in clk cycles (0 behaves as 1)
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high; until then the producer holds cmd_valid high and
// cmd_key/cmd_hold unchanged, and cmd_ready never depends on cmd_valid.
interface keypad_emulator_if #(
  parameter int HOLD_W = 24
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_key;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (output cmd_valid, output cmd_key, output cmd_hold, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_key, input cmd_hold, output cmd_ready);
endinterface

// File: rtl/keypad_emulator_lfsr16.sv
// lfsr16
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to randomise contact bounce.
//   clk, rst : clock, synchronous active-high reset (loads 16'hACE1)
//   en       : advance one step this cycle
//   state    : current register value
module lfsr16
  import keypad_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);
  logic [15:0] r_state;
  logic        w_fb;

  // Right-shifting form: tap n sits at bit (16-n), new bit enters at bit 15.
  assign w_fb = r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LFSR_SEED;
    end else if (en) begin
      r_state <= {w_fb, r_state[15:1]};
    end
  end

  assign state = r_state;
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator
// Behaves like one key of a 4x4 switch matrix being pressed on command:
// bounce on make, stable hold, bounce on break, then a released gap.
//   clk, rst       : clock, synchronous active-high reset
//   cmd (slave)    : key-press command channel
//   Col  (in)      : scanner column drive, active-low, bit3 = C1
//   Row  (out)     : row return, active-low, bit3 = R1, 4'b1111 when open
//   busy           : not idle
//   key_down       : contact currently closed (bounce closures included)
//   done           : one-cycle pulse on the last gap cycle
//   o_dbg          : FSM state, latched key, LFSR value
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 5000,
  parameter int BOUNCE_STEP   = 64,
  parameter int GAP_CYCLES    = 1000,
  parameter int HOLD_W        = 24
) (
  input  logic             clk,
  input  logic             rst,
  keypad_emulator_if.slave cmd,
  input  logic [3:0]       Col,
  output logic [3:0]       Row,
  output logic             busy,
  output logic             key_down,
  output logic             done,
  output dbg_t             o_dbg
);
  localparam int BG_MAX = (BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES;
  localparam int BG_W   = $clog2(BG_MAX + 1);
  localparam int CNT_W  = (HOLD_W > BG_W) ? HOLD_W : BG_W;
  localparam int STEP_W = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;

  // Counter holds "cycles left minus one" so each dwell is exact.
  localparam logic [CNT_W-1:0]  BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(BOUNCE_STEP - 1);

  state_e            r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next, w_hold_load;
  logic [3:0]        r_key, r_col, r_row;
  logic [HOLD_W-1:0] r_hold;
  logic [STEP_W-1:0] r_step;
  logic [15:0]       w_lfsr;
  logic              w_accept, w_in_bounce, w_lfsr_en;
  rc_t               w_rc;

  assign cmd.cmd_ready = (r_state == ST_IDLE);
  assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;
  assign w_rc          = key_to_rc(cmd.cmd_key);
  assign w_hold_load   = CNT_W'(r_hold - HOLD_W'(1));
  assign w_in_bounce   = (r_state == ST_BOUNCE_IN) || (r_state == ST_BOUNCE_OUT);
  assign w_lfsr_en     = w_in_bounce && (r_step == STEP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_key  <= cmd.cmd_key;
        r_col  <= w_rc.col;
        r_row  <= w_rc.row;
        r_hold <= (cmd.cmd_hold == '0) ? HOLD_W'(1) : cmd.cmd_hold;
      end
    end
  end

  // Bounce step divider; restarts at zero on every entry into a bounce state.
  always_ff @(posedge clk) begin
    if (rst || !w_in_bounce || w_lfsr_en) begin
      r_step <= '0;
    end else begin
      r_step <= r_step + STEP_W'(1);
    end
  end

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (w_lfsr_en),
    .state (w_lfsr)
  );

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    busy         = 1'b1;
    key_down     = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          w_next_state = ST_BOUNCE_IN;
          w_cnt_next   = BOUNCE_LOAD;
        end
      end
      ST_BOUNCE_IN: begin
        key_down = w_lfsr[0];
        if (r_cnt == '0) begin
          w_next_state = ST_HOLD;
          w_cnt_next   = w_hold_load;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        key_down = 1'b1;
        if (r_cnt == '0) begin
          w_next_state = ST_BOUNCE_OUT;
          w_cnt_next   = BOUNCE_LOAD;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_BOUNCE_OUT: begin
        key_down = w_lfsr[0];
        if (r_cnt == '0) begin
          w_next_state = ST_GAP;
          w_cnt_next   = GAP_LOAD;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          done         = 1'b1;
          w_next_state = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        busy         = 1'b0;
        w_next_state = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Wired-AND switch: any low column that includes ours pulls our row low.
  always_comb begin
    Row = 4'b1111;
    if (key_down && ((r_col & ~Col) != 4'b0000)) begin
      Row = ~r_row;
    end
  end

  assign o_dbg = '{state: r_state, key: r_key, lfsr: w_lfsr};
endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int B    = 16;
  localparam int STEP = 2;
  localparam int G    = 20;
  localparam int HW   = 24;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic [3:0] Col = 4'b1111;
  logic [3:0] Row;
  logic       busy, key_down, done;
  dbg_t       dbg;

  keypad_emulator_if #(.HOLD_W(HW)) cmd_if();

  keypad_emulator #(
    .BOUNCE_CYCLES (B),
    .BOUNCE_STEP   (STEP),
    .GAP_CYCLES    (G),
    .HOLD_W        (HW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_if),
    .Col      (Col),
    .Row      (Row),
    .busy     (busy),
    .key_down (key_down),
    .done     (done),
    .o_dbg    (dbg)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the printed keypad map (kmap[column][row]) and the
  // bounce LFSR as plain integer arithmetic.
  logic [3:0] kmap [0:3][0:3] = '{
    '{4'h1, 4'h4, 4'h7, 4'h0},
    '{4'h2, 4'h5, 4'h8, 4'hF},
    '{4'h3, 4'h6, 4'h9, 4'hE},
    '{4'hA, 4'hB, 4'hC, 4'hD}
  };
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'd1;
    return (s >> 1) | (b << 15);
  endfunction

  task automatic find_rc(input logic [3:0] key, output int c, output int r);
    c = 0;
    r = 0;
    for (int ci = 0; ci < 4; ci++)
      for (int ri = 0; ri < 4; ri++)
        if (kmap[ci][ri] == key) begin
          c = ci;
          r = ri;
        end
  endtask

  function automatic logic [3:0] model_row(input logic kd, input int c, input int r,
                                           input logic [3:0] col);
    logic [3:0] top;
    top = 4'b1000;
    if (kd && (col[3-c] == 1'b0)) return ~(top >> r);
    return 4'b1111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One press from accept through the gap. Entered and left on a negedge
  // with the emulator idle. Optional: chain the next command with valid
  // held, directed Col/Row pairs on the first two hold cycles, a column
  // scan decode, bounce toggle counting, and a reset at cycle abort_at.
  task automatic press(input logic [3:0] key, input logic [HW-1:0] hold,
                       input bit chain, input logic [3:0] nkey, input logic [HW-1:0] nhold,
                       input bit dir_en, input logic [3:0] dcol0, input logic [3:0] drow0,
                       input logic [3:0] dcol1, input logic [3:0] drow1,
                       input bit chk_tog, input bit do_scan, input int abort_at);
    int c, r, h, total, ph, j, tog_in, tog_out;
    logic kd, prev_obs;
    logic [3:0] rcol, dec;
    bit aborted, saw_done;
    logic [3:0] top;
    top = 4'b1000;
    find_rc(key, c, r);
    h = (hold == '0) ? 1 : int'(hold);
    total = 2 * B + h + G;
    tog_in = 0;
    tog_out = 0;
    prev_obs = 1'b0;
    aborted = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_key = key;
    cmd_if.cmd_hold = hold;
    chk("ready_before_accept", 32'(cmd_if.cmd_ready), 32'd1);
    @(posedge clk);
    for (int t = 1; t <= total && !aborted; t++) begin
      @(negedge clk);
      if (t == 1) begin
        if (chain) begin
          cmd_if.cmd_key = nkey;
          cmd_if.cmd_hold = nhold;
        end else begin
          cmd_if.cmd_valid = 1'b0;
        end
      end
      if (t <= B) begin ph = 1; j = t - 1; end
      else if (t <= B + h) begin ph = 2; j = t - B - 1; end
      else if (t <= 2 * B + h) begin ph = 3; j = t - B - h - 1; end
      else begin ph = 4; j = t - 2 * B - h - 1; end
      kd = (ph == 1 || ph == 3) ? m_lfsr[0] : (ph == 2);
      if (t == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        Col = ~(top >> c);
        #1;
        chk("rst_mid_row", 32'(Row), 32'hF);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("rst_mid_key_down", 32'(key_down), 32'd0);
        saw_done = 1'b0;
        repeat (total) begin
          @(negedge clk);
          if (done) saw_done = 1'b1;
        end
        chk("rst_mid_no_done", 32'(saw_done), 32'd0);
        aborted = 1'b1;
      end else begin
        rcol = 4'($urandom_range(0, 15));
        Col = rcol;
        #1;
        chk("busy", 32'(busy), 32'd1);
        chk("ready_low", 32'(cmd_if.cmd_ready), 32'd0);
        chk("key_down", 32'(key_down), 32'(kd));
        chk("done", 32'(done), 32'(t == total));
        chk("row_random_col", 32'(Row), 32'(model_row(kd, c, r, rcol)));
        if (dir_en && t == B + 1) begin
          Col = dcol0;
          #1;
          chk("row_directed0", 32'(Row), 32'(drow0));
        end
        if (dir_en && t == B + 2) begin
          Col = dcol1;
          #1;
          chk("row_directed1", 32'(Row), 32'(drow1));
        end
        if (do_scan && t == B + 1) begin
          dec = 4'bxxxx;
          for (int cc = 0; cc < 4; cc++) begin
            Col = ~(top >> cc);
            #1;
            for (int rr = 0; rr < 4; rr++)
              if (Row[3-rr] == 1'b0) dec = kmap[cc][rr];
          end
          chk("scan_decode", 32'(dec), 32'(key));
        end
        if (ph == 1 && j > 0 && key_down != prev_obs) tog_in++;
        if (ph == 3 && j > 0 && key_down != prev_obs) tog_out++;
        prev_obs = key_down;
        if ((ph == 1 || ph == 3) && ((j + 1) % STEP == 0)) m_lfsr = lfsr_next(m_lfsr);
      end
    end
    if (!aborted) begin
      @(negedge clk);
      rcol = 4'($urandom_range(0, 15));
      Col = rcol;
      #1;
      chk("ready_after_done", 32'(cmd_if.cmd_ready), 32'd1);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("done_single_pulse", 32'(done), 32'd0);
      chk("row_after_done", 32'(Row), 32'hF);
      if (chk_tog) begin
        chk("toggles_bounce_in_ge2", 32'(tog_in >= 2), 32'd1);
        chk("toggles_bounce_out_ge2", 32'(tog_out >= 2), 32'd1);
      end
    end
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_key = 4'h0;
    cmd_if.cmd_hold = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    Col = 4'b0000;
    #1;
    chk("reset_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_key_down", 32'(key_down), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_row", 32'(Row), 32'hF);
    chk("reset_lfsr", 32'(dbg.lfsr), 32'hACE1);
    chk("reset_state", 32'(dbg.state), 32'(ST_IDLE));
    rst = 1'b0;
    m_lfsr = 16'hACE1;

    // key 5, long hold, bounce toggles from the seed
    press(KEY_5, 1000, 0, 4'h0, '0, 1, 4'b1011, 4'b1011, 4'b0111, 4'b1111, 1, 0, 0);
    // back-to-back chain D -> 0 -> F with valid held high
    press(KEY_D, 20, 1, KEY_0, 15, 1, 4'b1110, 4'b1110, 4'b1101, 4'b1111, 0, 0, 0);
    press(KEY_0, 15, 1, KEY_F, 10, 1, 4'b0111, 4'b1110, 4'b1011, 4'b1111, 0, 0, 0);
    press(KEY_F, 10, 0, 4'h0, '0, 1, 4'b1011, 4'b1110, 4'b0111, 4'b1111, 0, 0, 0);
    // zero hold behaves as one cycle
    press(KEY_3, 0, 0, 4'h0, '0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    // column scan decodes key 9
    press(KEY_9, 8, 0, 4'h0, '0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 0);
    // reset mid-hold
    press(KEY_7, 50, 0, 4'h0, '0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, B + 10);
    // random presses after recovery
    for (int i = 0; i < 6; i++) begin
      press(4'($urandom_range(0, 15)), HW'($urandom_range(0, 30)), 0, 4'h0, '0,
            0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
